// File: rtl/vrf_bank_scheduler_pkg.sv
// Shared types and defaults for the VRF bank scheduler and its per-bank picker.
// Also holds the round-robin search helper used by every picker instance.
package vrf_bank_scheduler_pkg;

  localparam int NrBankDefault   = 8;
  localparam int MaxStallDefault = 4;
  localparam int BankAddrWidth   = 6;

  typedef logic [$clog2(NrBankDefault)-1:0] bank_id_t;
  typedef logic [BankAddrWidth-1:0]         bank_addr_t;

  typedef enum logic [1:0] {
    SchedStarved,
    SchedWrite,
    SchedRead
  } sched_class_e;

  // Widest class any picker searches; candidate vectors are zero-extended to this.
  localparam int RrMax = 16;

  // First set bit at index >= ptr, wrapping within n entries; -1 when none.
  function automatic int rr_pick(input logic [RrMax-1:0] cand, input int n, input int ptr);
    int j;
    int res;
    res = -1;
    for (int k = 0; k < RrMax; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (res < 0 && cand[j[3:0]]) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vrf_bank_picker.sv
// Single-bank winner selection: starved reads, then writes, then reads, each class round-robin.
// Purely combinational; pointer and stall state live in the scheduler top.
module vrf_bank_picker
  import vrf_bank_scheduler_pkg::*;
#(
  parameter int NrRead  = 3,
  parameter int NrWrite = 2,
  parameter int IdxW    = 2
) (
  input  logic [NrRead-1:0]         rd_cand_i,
  input  logic [NrWrite-1:0]        wr_cand_i,
  input  logic [NrRead-1:0]         starved_i,
  input  logic [IdxW-1:0]           rd_ptr_i,
  input  logic [IdxW-1:0]           wr_ptr_i,
  output logic                      win_o,
  output sched_class_e              cls_o,
  output logic [IdxW-1:0]           idx_o,
  output logic [NrRead+NrWrite-1:0] gnt_o
);

  localparam int NrReq = NrRead + NrWrite;

  int s_idx;
  int w_idx;
  int r_idx;

  always_comb begin
    s_idx = rr_pick(RrMax'(rd_cand_i & starved_i), NrRead, int'(rd_ptr_i));
    w_idx = rr_pick(RrMax'(wr_cand_i), NrWrite, int'(wr_ptr_i));
    r_idx = rr_pick(RrMax'(rd_cand_i), NrRead, int'(rd_ptr_i));
    win_o = 1'b0;
    cls_o = SchedRead;
    idx_o = '0;
    gnt_o = '0;
    if (s_idx >= 0) begin
      win_o = 1'b1;
      cls_o = SchedStarved;
      idx_o = IdxW'(s_idx);
      gnt_o = NrReq'(1) << s_idx;
    end else if (w_idx >= 0) begin
      win_o = 1'b1;
      cls_o = SchedWrite;
      idx_o = IdxW'(w_idx);
      gnt_o = NrReq'(1) << (NrRead + w_idx);
    end else if (r_idx >= 0) begin
      win_o = 1'b1;
      cls_o = SchedRead;
      idx_o = IdxW'(r_idx);
      gnt_o = NrReq'(1) << r_idx;
    end
  end

endmodule

// File: rtl/vrf_bank_scheduler.sv
// Per-bank arbiter for the lane VRF: combinational grants, bank port muxing, 1-cycle read return.
// Optional per-bank conflict counters are built when VRF_BANK_SCHED_STATS_EN is defined.
module vrf_bank_scheduler
  import vrf_bank_scheduler_pkg::*;
#(
  parameter int NrRead    = 3,
  parameter int NrWrite   = 2,
  parameter int NrBank    = vrf_bank_scheduler_pkg::NrBankDefault,
  parameter int AddrWidth = 6,
  parameter int DataWidth = 64,
  parameter int MaxStall  = vrf_bank_scheduler_pkg::MaxStallDefault,
  localparam int NrReq    = NrRead + NrWrite,
  localparam int BankW    = $clog2(NrBank),
  localparam int StrbW    = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrReq-1:0]                    req_i,
  input  logic [NrReq-1:0][BankW-1:0]         bank_sel_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NrWrite-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NrWrite-1:0][StrbW-1:0]       wstrb_i,
  output logic [NrReq-1:0]                    gnt_o,
  output logic [NrBank-1:0]                   bank_req_o,
  output logic [NrBank-1:0]                   bank_wen_o,
  output logic [NrBank-1:0][AddrWidth-1:0]    bank_addr_o,
  output logic [NrBank-1:0][DataWidth-1:0]    bank_wdata_o,
  output logic [NrBank-1:0][StrbW-1:0]        bank_wstrb_o,
  input  logic [NrBank-1:0][DataWidth-1:0]    bank_rdata_i,
  output logic [NrRead-1:0][DataWidth-1:0]    rdata_o,
  output logic [NrRead-1:0]                   rdata_valid_o,
  output logic [NrBank-1:0][31:0]             conflict_cnt_o
);

  localparam int IdxMax = (NrRead > NrWrite) ? NrRead : NrWrite;
  localparam int IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;
  localparam int StallW = $clog2(MaxStall + 1);

  logic [NrReq-1:0]  cand     [NrBank];
  logic [NrRead-1:0] starved;
  logic [IdxW-1:0]   rd_ptr_q [NrBank];
  logic [IdxW-1:0]   wr_ptr_q [NrBank];
  logic [StallW-1:0] stall_cnt_q [NrRead];

  logic              win      [NrBank];
  sched_class_e      win_cls  [NrBank];
  logic [IdxW-1:0]   win_idx  [NrBank];
  logic [NrReq-1:0]  bank_gnt [NrBank];

  logic [NrRead-1:0]            rd_valid_q;
  logic [NrRead-1:0][BankW-1:0] rd_bank_q;

  always_comb begin
    for (int b = 0; b < NrBank; b++) begin
      cand[b] = '0;
      for (int q = 0; q < NrReq; q++) begin
        cand[b][q] = req_i[q] && (bank_sel_i[q] == BankW'(b));
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int r = 0; r < NrRead; r++) begin
      starved[r] = (stall_cnt_q[r] == StallW'(MaxStall));
    end
  end

  for (genvar b = 0; b < NrBank; b++) begin : g_bank
    vrf_bank_picker #(
      .NrRead (NrRead),
      .NrWrite(NrWrite),
      .IdxW   (IdxW)
    ) u_picker (
      .rd_cand_i(cand[b][NrRead-1:0]),
      .wr_cand_i(cand[b][NrReq-1:NrRead]),
      .starved_i(starved),
      .rd_ptr_i (rd_ptr_q[b]),
      .wr_ptr_i (wr_ptr_q[b]),
      .win_o    (win[b]),
      .cls_o    (win_cls[b]),
      .idx_o    (win_idx[b]),
      .gnt_o    (bank_gnt[b])
    );
  end

  // Each requester targets exactly one bank, so OR-ing per-bank one-hots is exact.
  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NrBank; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
    end
  end

  always_comb begin
    bank_req_o   = '0;
    bank_wen_o   = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_wstrb_o = '0;
    for (int b = 0; b < NrBank; b++) begin
      bank_req_o[b] = win[b];
      for (int r = 0; r < NrRead; r++) begin
        if (bank_gnt[b][r]) bank_addr_o[b] = addr_i[r];
      end
      for (int w = 0; w < NrWrite; w++) begin
        if (bank_gnt[b][NrRead+w]) begin
          bank_wen_o[b]   = 1'b1;
          bank_addr_o[b]  = addr_i[NrRead+w];
          bank_wdata_o[b] = wdata_i[w];
          bank_wstrb_o[b] = wstrb_i[w];
        end
      end
    end
  end

  // Starved grants come from the read class, so they advance the read pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NrBank; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NrBank; b++) begin
        if (win[b]) begin
          if (win_cls[b] == SchedWrite) begin
            wr_ptr_q[b] <= (win_idx[b] == IdxW'(NrWrite - 1)) ? '0 : win_idx[b] + IdxW'(1);
          end else begin
            rd_ptr_q[b] <= (win_idx[b] == IdxW'(NrRead - 1)) ? '0 : win_idx[b] + IdxW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NrRead; r++) stall_cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NrRead; r++) begin
        if (req_i[r] && !gnt_o[r]) begin
          if (stall_cnt_q[r] != StallW'(MaxStall)) stall_cnt_q[r] <= stall_cnt_q[r] + StallW'(1);
        end else begin
          stall_cnt_q[r] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_valid_q <= '0;
    else         rd_valid_q <= gnt_o[NrRead-1:0];
  end

  // Bank id only matters while rd_valid_q is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    rd_bank_q <= bank_sel_i[NrRead-1:0];
  end

  always_comb begin
    for (int r = 0; r < NrRead; r++) begin
      rdata_o[r] = bank_rdata_i[rd_bank_q[r]];
    end
  end

  assign rdata_valid_o = rd_valid_q;

`ifdef VRF_BANK_SCHED_STATS_EN
  logic [31:0] conflict_q [NrBank];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NrBank; b++) conflict_q[b] <= '0;
    end else begin
      for (int b = 0; b < NrBank; b++) begin
        if ($countones(cand[b]) >= 2) conflict_q[b] <= conflict_q[b] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NrBank; b++) conflict_cnt_o[b] = conflict_q[b];
  end
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vrf_bank_scheduler.sv
// Bench for vrf_bank_scheduler: directed scenarios plus randomized traffic checked against a
// rule-level reference model, with a bank memory model feeding bank_rdata_i.
module tb_vrf_bank_scheduler;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int NQ = NR + NW;
  localparam int NB = 8;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [NQ-1:0]          req;
  logic [NQ-1:0][2:0]     bank_sel;
  logic [NQ-1:0][AW-1:0]  addr;
  logic [NW-1:0][DW-1:0]  wdata;
  logic [NW-1:0][SW-1:0]  wstrb;
  logic [NQ-1:0]          gnt;
  logic [NB-1:0]          bank_req;
  logic [NB-1:0]          bank_wen;
  logic [NB-1:0][AW-1:0]  bank_addr;
  logic [NB-1:0][DW-1:0]  bank_wdata;
  logic [NB-1:0][SW-1:0]  bank_wstrb;
  logic [NB-1:0][DW-1:0]  bank_rdata;
  logic [NR-1:0][DW-1:0]  rdata;
  logic [NR-1:0]          rdata_valid;
  logic [NB-1:0][31:0]    conflict_cnt;

  vrf_bank_scheduler #(
    .NrRead(NR), .NrWrite(NW), .NrBank(NB), .AddrWidth(AW), .DataWidth(DW), .MaxStall(MS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .bank_sel_i(bank_sel), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .gnt_o(gnt), .bank_req_o(bank_req),
    .bank_wen_o(bank_wen), .bank_addr_o(bank_addr), .bank_wdata_o(bank_wdata),
    .bank_wstrb_o(bank_wstrb), .bank_rdata_i(bank_rdata), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .conflict_cnt_o(conflict_cnt)
  );

  // Reference model state
  int               m_rd_ptr [NB];
  int               m_wr_ptr [NB];
  int               m_stall  [NR];
  logic [NR-1:0]    m_valid;
  logic [31:0]      m_conf   [NB];
  logic [DW-1:0]    mem      [NB][64];
  logic [DW-1:0]    exp_q[$];

  int               e_win    [NB];
  int               e_ncand  [NB];
  logic [NQ-1:0]         e_gnt;
  logic [NB-1:0]         e_breq, e_wen;
  logic [NB-1:0][AW-1:0] e_addr;
  logic [NB-1:0][DW-1:0] e_wdata;
  logic [NB-1:0][SW-1:0] e_wstrb;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_rd_ptr[b] = 0; m_wr_ptr[b] = 0; m_conf[b] = '0;
    end
    for (int r = 0; r < NR; r++) m_stall[r] = 0;
    m_valid = '0;
    exp_q.delete();
  endtask

  function automatic bit targets(int q, int b);
    return req[q] && (int'(bank_sel[q]) == b);
  endfunction

  task automatic model_eval();
    int best;
    e_gnt = '0; e_breq = '0; e_wen = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    for (int b = 0; b < NB; b++) begin
      best = -1;
      e_ncand[b] = 0;
      for (int q = 0; q < NQ; q++) if (targets(q, b)) e_ncand[b]++;
      for (int k = 0; k < NR; k++)
        if (best < 0 && targets((m_rd_ptr[b] + k) % NR, b) && m_stall[(m_rd_ptr[b] + k) % NR] == MS)
          best = (m_rd_ptr[b] + k) % NR;
      for (int k = 0; k < NW; k++)
        if (best < 0 && targets(NR + (m_wr_ptr[b] + k) % NW, b)) best = NR + (m_wr_ptr[b] + k) % NW;
      for (int k = 0; k < NR; k++)
        if (best < 0 && targets((m_rd_ptr[b] + k) % NR, b)) best = (m_rd_ptr[b] + k) % NR;
      e_win[b] = best;
      if (best >= 0) begin
        e_gnt[best] = 1'b1;
        e_breq[b] = 1'b1;
        e_addr[b] = addr[best];
        if (best >= NR) begin
          e_wen[b] = 1'b1;
          e_wdata[b] = wdata[best-NR];
          e_wstrb[b] = wstrb[best-NR];
        end
      end
    end
  endtask

  task automatic check_outputs(string tag);
    logic [DW-1:0] exp_d;
    logic [31:0] exp_c;
    checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL %s gnt_o: got %b expected %b", tag, gnt, e_gnt); end
    checks++; if (bank_req !== e_breq) begin errors++; $display("FAIL %s bank_req_o: got %b expected %b", tag, bank_req, e_breq); end
    checks++; if (bank_wen !== e_wen) begin errors++; $display("FAIL %s bank_wen_o: got %b expected %b", tag, bank_wen, e_wen); end
    checks++; if (bank_addr !== e_addr) begin errors++; $display("FAIL %s bank_addr_o: got %h expected %h", tag, bank_addr, e_addr); end
    checks++; if (bank_wdata !== e_wdata) begin errors++; $display("FAIL %s bank_wdata_o mismatch", tag); end
    checks++; if (bank_wstrb !== e_wstrb) begin errors++; $display("FAIL %s bank_wstrb_o: got %h expected %h", tag, bank_wstrb, e_wstrb); end
    checks++; if (rdata_valid !== m_valid) begin errors++; $display("FAIL %s rdata_valid_o: got %b expected %b", tag, rdata_valid, m_valid); end
    for (int r = 0; r < NR; r++) begin
      if (m_valid[r]) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (rdata[r] !== exp_d) begin errors++; $display("FAIL %s rdata_o[%0d]: got %h expected %h", tag, r, rdata[r], exp_d); end
      end
    end
    for (int b = 0; b < NB; b++) begin
`ifdef VRF_BANK_SCHED_STATS_EN
      exp_c = m_conf[b];
`else
      exp_c = '0;
`endif
      checks++;
      if (conflict_cnt[b] !== exp_c) begin errors++; $display("FAIL %s conflict_cnt_o[%0d]: got %0d expected %0d", tag, b, conflict_cnt[b], exp_c); end
    end
  endtask

  task automatic model_commit(output bit rd_pend [NB], output int rd_addr [NB]);
    for (int b = 0; b < NB; b++) begin rd_pend[b] = 1'b0; rd_addr[b] = 0; end
    for (int r = 0; r < NR; r++) if (e_gnt[r]) exp_q.push_back(mem[bank_sel[r]][addr[r]]);
    for (int b = 0; b < NB; b++) begin
      if (e_win[b] >= NR) begin
        m_wr_ptr[b] = (e_win[b] - NR + 1) % NW;
        for (int i = 0; i < SW; i++)
          if (e_wstrb[b][i]) mem[b][e_addr[b]][8*i +: 8] = e_wdata[b][8*i +: 8];
      end else if (e_win[b] >= 0) begin
        m_rd_ptr[b] = (e_win[b] + 1) % NR;
        rd_pend[b] = 1'b1;
        rd_addr[b] = int'(e_addr[b]);
      end
      if (e_ncand[b] >= 2) m_conf[b] = m_conf[b] + 32'd1;
    end
    for (int r = 0; r < NR; r++)
      m_stall[r] = (req[r] && !e_gnt[r]) ? ((m_stall[r] < MS) ? m_stall[r] + 1 : MS) : 0;
    m_valid = e_gnt[NR-1:0];
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle_check(string tag);
    bit rd_pend [NB];
    int rd_addr [NB];
    #2;
    model_eval();
    check_outputs(tag);
    @(posedge clk);
    model_commit(rd_pend, rd_addr);
    #1;
    for (int b = 0; b < NB; b++)
      bank_rdata[b] = rd_pend[b] ? mem[b][rd_addr[b]] : {$urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; bank_sel = '0; addr = '0; wdata = '0; wstrb = '0;
  endtask

  task automatic expect_gnt(string tag, logic [NQ-1:0] exp);
    #1;
    checks++;
    if (gnt !== exp) begin errors++; $display("FAIL %s gnt_o: got %b expected %b", tag, gnt, exp); end
  endtask

  task automatic idle();
    clear_inputs();
    cycle_check("idle");
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdata_valid !== '0) begin errors++; $display("FAIL reset rdata_valid_o: got %b expected 0", rdata_valid); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset gnt_o: got %b expected 0", gnt); end
    checks++; if (bank_req !== '0) begin errors++; $display("FAIL reset bank_req_o: got %b expected 0", bank_req); end
    checks++; if (conflict_cnt !== '0) begin errors++; $display("FAIL reset conflict_cnt_o: got %h expected 0", conflict_cnt); end
    model_reset();
    rst_ni = 1'b1;
  endtask

  task automatic test_read_rr();
    logic [NQ-1:0] seq [4] = '{5'b00001, 5'b00010, 5'b00001, 5'b00010};
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      req = 5'b00011; bank_sel[0] = 3'd2; bank_sel[1] = 3'd2; addr[0] = AW'(c); addr[1] = AW'(c + 8);
      expect_gnt("read_rr", seq[c]);
      if (c > 0) begin
        checks++;
        if (rdata_valid !== seq[c-1][NR-1:0]) begin errors++; $display("FAIL read_rr rdata_valid_o: got %b expected %b", rdata_valid, seq[c-1][NR-1:0]); end
      end
      cycle_check("read_rr");
    end
`ifdef VRF_BANK_SCHED_STATS_EN
    checks++;
    if (conflict_cnt[2] !== 32'd4) begin errors++; $display("FAIL read_rr conflict_cnt_o[2]: got %0d expected 4", conflict_cnt[2]); end
`endif
    idle();
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      req = 5'b01001; bank_sel[0] = 3'd1; bank_sel[3] = 3'd1; addr[0] = 6'd3; addr[3] = 6'd4;
      wdata[0] = {$urandom, $urandom}; wstrb[0] = 8'hff;
      expect_gnt("starvation", (c == 4) ? 5'b00001 : 5'b01000);
      cycle_check("starvation");
    end
    idle();
  endtask

  task automatic test_all_banks();
    clear_inputs();
    req = 5'b11111;
    for (int q = 0; q < NQ; q++) begin bank_sel[q] = 3'(q); addr[q] = 6'($urandom_range(0, 63)); end
    wdata[0] = {$urandom, $urandom}; wdata[1] = {$urandom, $urandom}; wstrb[0] = 8'h0f; wstrb[1] = 8'hf0;
    expect_gnt("all_banks", 5'b11111);
    checks++;
    if (bank_req !== 8'b00011111) begin errors++; $display("FAIL all_banks bank_req_o: got %b expected 00011111", bank_req); end
    cycle_check("all_banks");
    idle();
  endtask

  task automatic test_read_return();
    mem[5][7] = 64'hDEAD;
    clear_inputs();
    req = 5'b00100; bank_sel[2] = 3'd5; addr[2] = 6'd7;
    cycle_check("read_return");
    clear_inputs();
    #1;
    checks++;
    if (rdata[2] !== 64'hDEAD || rdata_valid[2] !== 1'b1) begin
      errors++; $display("FAIL read_return rdata_o[2]: got %h/%b expected dead/1", rdata[2], rdata_valid[2]);
    end
    cycle_check("read_return");
  endtask

  task automatic test_drop_req();
    logic [NQ-1:0] seq [9] = '{5'b01000, 5'b01000, 5'b01000, 5'b01000,
                               5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00010};
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      req = (c == 3) ? 5'b01000 : 5'b01010;
      bank_sel[1] = 3'd6; bank_sel[3] = 3'd6; addr[1] = 6'd9; addr[3] = 6'd10;
      wdata[0] = {$urandom, $urandom}; wstrb[0] = 8'($urandom);
      expect_gnt("drop_req", seq[c]);
      cycle_check("drop_req");
    end
    idle();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    req = 5'b00001; bank_sel[0] = 3'd2; addr[0] = 6'd1;
    cycle_check("reset_mid");
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rdata_valid !== '0) begin errors++; $display("FAIL reset_mid rdata_valid_o: got %b expected 0", rdata_valid); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    clear_inputs();
    req = 5'b00011; bank_sel[0] = 3'd2; bank_sel[1] = 3'd2;
    expect_gnt("reset_mid_ptr", 5'b00001);
    cycle_check("reset_mid_ptr");
    idle();
  endtask

  task automatic test_random(int cycles, int max_bank, bit heavy_wr);
    for (int c = 0; c < cycles; c++) begin
      req = NQ'($urandom);
      if (heavy_wr) req[NQ-1:NR] = '1;
      for (int q = 0; q < NQ; q++) begin
        bank_sel[q] = 3'($urandom_range(0, max_bank));
        addr[q] = 6'($urandom_range(0, 63));
      end
      for (int w = 0; w < NW; w++) begin
        wdata[w] = {$urandom, $urandom};
        wstrb[w] = 8'($urandom);
      end
      cycle_check("random");
    end
    idle();
  endtask

  initial begin
    clear_inputs();
    bank_rdata = '0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 64; a++) mem[b][a] = {$urandom, $urandom};
    test_reset();
    test_read_rr();
    test_starvation();
    test_all_banks();
    test_read_return();
    test_drop_req();
    test_reset_mid();
    test_random(300, 7, 1'b0);
    test_random(300, 1, 1'b1);
    test_random(200, 3, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
